// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
//   Run/pause/lap/clear sequencer for a BCD stopwatch. It drives a 10 ms
//   (TICK_HZ) count strobe into the time counters and a free-running
//   digit-scan index for the multiplexed display.
//
//   Optional feature macro: STOPWATCH_LAP_EN (enables the LAP state and
//   btn_lap handling; when undefined, lap_hold is tied low and the LAP code
//   is treated as illegal).
//
//   Ports
//     clk        system clock, rising edge
//     reset      asynchronous active-low reset
//     btn_start  one-cycle pulse: toggle run/pause
//     btn_clear  one-cycle pulse: clear time (IDLE or PAUSE only)
//     btn_lap    one-cycle pulse: toggle lap hold (RUN/LAP only)
//     cnt_en     one-cycle increment strobe to the LSB counter
//     cnt_clr    one-cycle synchronous clear to the time counters
//     lap_hold   display shows latched digits while high
//     sel[2:0]   digit scan index, 0 = LSB digit
//     state[1:0] FSM state code
//
//   state | meaning
//   IDLE  | stopped, time cleared or clearable (00)
//   RUN   | counting (01)
//   PAUSE | stopped, time preserved (10)
//   LAP   | counting, display frozen (11)
module stopwatch_ctrl #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 100,
  parameter int SCAN_HZ = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_clear,
  input  logic       btn_lap,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       lap_hold,
  output logic [2:0] sel,
  output logic [1:0] state
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int TICK_W   = $clog2(TICK_DIV);
  localparam int SCAN_W   = $clog2(SCAN_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  if (TICK_DIV < 2 || TICK_DIV * TICK_HZ != CLK_HZ) begin : g_bad_tick
    $error("stopwatch_ctrl: CLK_HZ/TICK_HZ must be an integer >= 2");
  end
  if (SCAN_DIV < 2 || SCAN_DIV * SCAN_HZ != CLK_HZ) begin : g_bad_scan
    $error("stopwatch_ctrl: CLK_HZ/SCAN_HZ must be an integer >= 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_LAP   = 2'b11
  } state_e;

  state_e             state_q, state_d;
  logic               cnt_clr_q, cnt_clr_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [SCAN_W-1:0]  scan_q, scan_d;
  logic [2:0]         sel_q, sel_d;
  logic               counting;
  logic               tick_last;
  logic               start_ev, clear_ev;

`ifdef STOPWATCH_LAP_EN
  logic lap_ev;
  logic lap_hold_q, lap_hold_d;
`else
  logic unused_lap;
  assign unused_lap = btn_lap;
`endif

  // Only one pulse is acted on per cycle: start beats clear beats lap.
  always_comb begin
    start_ev  = btn_start;
    clear_ev  = btn_clear & ~btn_start;
`ifdef STOPWATCH_LAP_EN
    lap_ev    = btn_lap & ~btn_start & ~btn_clear;
`endif
    state_d   = state_q;
    cnt_clr_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_ev)      state_d   = ST_RUN;
        else if (clear_ev) cnt_clr_d = 1'b1;
      end
      ST_RUN: begin
        if (start_ev)    state_d = ST_PAUSE;
`ifdef STOPWATCH_LAP_EN
        else if (lap_ev) state_d = ST_LAP;
`endif
      end
      ST_PAUSE: begin
        if (start_ev) begin
          state_d = ST_RUN;
        end else if (clear_ev) begin
          state_d   = ST_IDLE;
          cnt_clr_d = 1'b1;
        end
      end
`ifdef STOPWATCH_LAP_EN
      ST_LAP: begin
        if (start_ev)    state_d = ST_PAUSE;
        else if (lap_ev) state_d = ST_RUN;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
`ifdef STOPWATCH_LAP_EN
    lap_hold_d = (state_d == ST_LAP);
`endif
  end

`ifdef STOPWATCH_LAP_EN
  assign counting = (state_q == ST_RUN) || (state_q == ST_LAP);
`else
  assign counting = (state_q == ST_RUN);
`endif

  assign tick_last = (tick_q == TICK_LAST);

  // Tick prescaler holds its partial interval through PAUSE so resuming
  // does not restart the current 10 ms slot.
  always_comb begin
    tick_d = tick_q;
    if (cnt_clr_q)     tick_d = '0;
    else if (counting) tick_d = tick_last ? '0 : tick_q + TICK_W'(1);
  end

  always_comb begin
    scan_d = scan_q;
    sel_d  = sel_q;
    if (scan_q == SCAN_LAST) begin
      scan_d = '0;
      sel_d  = sel_q + 3'd1;
    end else begin
      scan_d = scan_q + SCAN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_clr_q <= 1'b0;
      tick_q    <= '0;
      scan_q    <= '0;
      sel_q     <= 3'd0;
    end else begin
      state_q   <= state_d;
      cnt_clr_q <= cnt_clr_d;
      tick_q    <= tick_d;
      scan_q    <= scan_d;
      sel_q     <= sel_d;
    end
  end

`ifdef STOPWATCH_LAP_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lap_hold_q <= 1'b0;
    else        lap_hold_q <= lap_hold_d;
  end
  assign lap_hold = lap_hold_q;
`else
  assign lap_hold = 1'b0;
`endif

  assign cnt_en  = counting & tick_last;
  assign cnt_clr = cnt_clr_q;
  assign sel     = sel_q;
  assign state   = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Testbench for stopwatch_ctrl (CLK_HZ=1000, TICK_HZ=100, SCAN_HZ=250).
// Stimulus pushes the expected output word for each cycle into a queue; a
// monitor on the falling edge pops and compares it against the DUT.
module tb_stopwatch_ctrl;

  localparam int CLK_HZ   = 1000;
  localparam int TICK_HZ  = 100;
  localparam int SCAN_HZ  = 250;
  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_LAP   = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_clear = 1'b0;
  logic       btn_lap = 1'b0;
  logic       cnt_en, cnt_clr, lap_hold;
  logic [2:0] sel;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // expected word: {state[1:0], sel[2:0], cnt_en, cnt_clr, lap_hold}
  logic [7:0] exp_q[$];

  // reference model: stopwatch mode, total counting cycles since the last
  // clear, and clock edges since reset release
  int m_mode  = M_IDLE;
  bit m_clr   = 1'b0;
  int m_run   = 0;
  int m_edges = 0;

  stopwatch_ctrl #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .SCAN_HZ(SCAN_HZ)) dut (
    .clk(clk), .reset(reset),
    .btn_start(btn_start), .btn_clear(btn_clear), .btn_lap(btn_lap),
    .cnt_en(cnt_en), .cnt_clr(cnt_clr), .lap_hold(lap_hold),
    .sel(sel), .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] outs();
    return {state, sel, cnt_en, cnt_clr, lap_hold};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_counting(input int mode);
    return (mode == M_RUN) || (mode == M_LAP);
  endfunction

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_clr   = 1'b0;
    m_run   = 0;
    m_edges = 0;
  endtask

  // Called at each rising edge with the buttons sampled there.
  task automatic model_edge(input logic s, input logic c, input logic l);
    logic [7:0] e;
    bit en;
    if (!reset) begin
      model_reset();
      exp_q.push_back(8'h00);
      return;
    end
    if (m_clr) m_run = 0;
    else if (is_counting(m_mode)) m_run++;
    m_edges++;
    m_clr = 1'b0;
    if (s) begin
      if (m_mode == M_IDLE || m_mode == M_PAUSE) m_mode = M_RUN;
      else m_mode = M_PAUSE;
    end else if (c) begin
      if (m_mode == M_IDLE) m_clr = 1'b1;
      else if (m_mode == M_PAUSE) begin
        m_mode = M_IDLE;
        m_clr  = 1'b1;
      end
    end else if (l && LAP_EN) begin
      if (m_mode == M_RUN) m_mode = M_LAP;
      else if (m_mode == M_LAP) m_mode = M_RUN;
    end
    en = is_counting(m_mode) && ((m_run % TICK_DIV) == TICK_DIV - 1);
    e = {2'(m_mode), 3'((m_edges / SCAN_DIV) % 8), en, m_clr, (m_mode == M_LAP)};
    exp_q.push_back(e);
  endtask

  // Drive buttons for one cycle; returns 1 time unit after the edge.
  task automatic step(input logic s, input logic c, input logic l);
    btn_start = s;
    btn_clear = c;
    btn_lap   = l;
    @(posedge clk);
    model_edge(s, c, l);
    #1;
    btn_start = 1'b0;
    btn_clear = 1'b0;
    btn_lap   = 1'b0;
  endtask

  // Reset asserted mid-cycle: outputs must drop before the next edge.
  task automatic pulse_reset(input int ncyc);
    reset = 1'b0;
    #1;
    check("async_reset_outputs", int'(outs()), 0);
    if (exp_q.size() != 0) exp_q[exp_q.size() - 1] = 8'h00;
    model_reset();
    repeat (ncyc) step(1'b0, 1'b0, 1'b0);
    reset = 1'b1;
  endtask

  task automatic latency_to_en(output int n);
    n = 1;
    while (!cnt_en && n < 40) begin
      step(1'b0, 1'b0, 1'b0);
      n++;
    end
  endtask

  // monitor
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        total++;
        if (outs() !== e) begin
          bad++;
          $display("FAIL outputs cycle %0d: got st=%b sel=%0d en=%b clr=%b lap=%b expected st=%b sel=%0d en=%b clr=%b lap=%b",
                   cyc, state, sel, cnt_en, cnt_clr, lap_hold,
                   e[7:6], e[5:3], e[2], e[1], e[0]);
        end
      end
    end
  end

  initial begin
    int n;
    int cnt;
    #2;
    check("reset_outputs_no_clock", int'(outs()), 0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    reset = 1'b1;

    // start after a few idle cycles; first strobe 10 cycles after start
    repeat (4) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("start_state_run", int'(state), M_RUN);
    latency_to_en(n);
    check("first_en_latency", n, 10);
    repeat (25) step(1'b0, 1'b0, 1'b0);

    // pause then clear
    step(1'b1, 1'b0, 1'b0);
    check("pause_state", int'(state), M_PAUSE);
    step(1'b0, 1'b1, 1'b0);
    check("clear_state_idle", int'(state), M_IDLE);
    check("clear_pulse", int'(cnt_clr), 1);
    step(1'b0, 1'b0, 1'b0);
    check("clear_one_cycle", int'(cnt_clr), 0);
    step(1'b1, 1'b0, 1'b0);
    latency_to_en(n);
    check("en_latency_after_clear", n, 10);

    // partial interval survives a 20-cycle pause
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    repeat (6) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    cnt = int'(cnt_en);
    repeat (19) begin
      step(1'b0, 1'b0, 1'b0);
      cnt += int'(cnt_en);
    end
    check("no_en_in_pause", cnt, 0);
    step(1'b1, 1'b0, 1'b0);
    latency_to_en(n);
    check("en_latency_after_resume", n, 3);

    // simultaneous pulses
    step(1'b1, 1'b1, 1'b0);
    check("start_beats_clear_state", int'(state), M_PAUSE);
    check("start_beats_clear_noclr", int'(cnt_clr), 0);
    step(1'b0, 1'b1, 1'b1);
    check("clear_beats_lap_state", int'(state), M_IDLE);
    check("clear_beats_lap_clr", int'(cnt_clr), 1);

    // lap hold
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    check("lap_hold_set", int'(lap_hold), LAP_EN ? 1 : 0);
    cnt = 0;
    repeat (30) begin
      step(1'b0, 1'b0, 1'b0);
      cnt += int'(cnt_en);
    end
    check("en_count_in_lap", cnt, 3);
    step(1'b0, 1'b0, 1'b1);
    check("lap_hold_clear", int'(lap_hold), 0);

    // reset mid-LAP (mid-RUN without the lap feature)
    step(1'b0, 1'b0, 1'b1);
    repeat (5) step(1'b0, 1'b0, 1'b0);
    pulse_reset(2);
    cnt = 0;
    repeat (30) begin
      step(1'b0, 1'b0, 1'b0);
      cnt += int'(cnt_en) + int'(cnt_clr);
    end
    check("no_pulse_after_reset", cnt, 0);
    check("idle_after_reset", int'(state), M_IDLE);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        pulse_reset($urandom_range(1, 3));
      end else begin
        step($urandom_range(0, 11) == 0, $urandom_range(0, 13) == 0,
             $urandom_range(0, 9) == 0);
      end
    end

    repeat (2) @(negedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
